// File: rtl/adder_issue_stage.sv
// adder_issue_stage
//   Two-stage registered wrapper around an external combinational adder.
//   Stage 1 captures operands from a valid/ready source and drives the adder.
//   Stage 2 captures the sum and carry, derives signed overflow, and presents
//   the result to a valid/ready sink.
//   Optional build macro: ADDER_ISSUE_CHECK_EN. When it is defined, every
//   stage-2 load is compared against an internal reference sum, and chk_err
//   sets and stays set on a mismatch. When it is undefined, chk_err is tied to 0.
module adder_issue_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // operand source
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  // combinational adder interface
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_f,
  input  logic             add_cout,
  // result sink
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_cout,
  output logic             out_ovf,
  // status
  output logic [CNT_W-1:0] op_count,
  output logic             chk_err
);

  localparam int MSB = WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // stage 1 operand registers
  logic             s1_valid_reg, s1_valid_next;
  logic [WIDTH-1:0] s1_a_reg, s1_a_next;
  logic [WIDTH-1:0] s1_b_reg, s1_b_next;
  logic             s1_cin_reg, s1_cin_next;

  // stage 2 result registers
  logic             s2_valid_reg, s2_valid_next;
  logic [WIDTH-1:0] out_f_reg, out_f_next;
  logic             out_cout_reg, out_cout_next;
  logic             out_ovf_reg, out_ovf_next;

  // completed-transfer counter
  logic [CNT_W-1:0] op_count_reg, op_count_next;

  // handshake and advance strobes
  logic s2_free;
  logic in_fire;
  logic out_fire;
  logic s2_load;
  logic ovf_calc;

  // Stage 2 can take new data when it is empty or is draining this cycle.
  // Stage 1 can accept when empty or when its content moves to stage 2,
  // so a release of back-pressure can transfer out and accept in one cycle.
  assign s2_free  = !s2_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_reg && out_ready;
  assign s2_load  = s1_valid_reg && s2_free;

  // Signed overflow: both operands share a sign and the sum's sign differs.
  assign ovf_calc = (s1_a_reg[MSB] == s1_b_reg[MSB]) && (add_f[MSB] != s1_a_reg[MSB]);

  // Adder inputs are forced to zero while stage 1 is empty, so the adder
  // sees a quiet bus between operations. Stage-1 registers hold during a
  // stall, which keeps the adder inputs constant.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_drive
      assign add_a[gi] = s1_a_reg[gi] & s1_valid_reg;
      assign add_b[gi] = s1_b_reg[gi] & s1_valid_reg;
    end
  endgenerate
  assign add_cin = s1_cin_reg & s1_valid_reg;

  // Stage 1 next state: load on an input transfer, empty when handing off
  // to stage 2 with nothing new arriving, otherwise hold.
  always_comb begin
    s1_valid_next = s1_valid_reg;
    s1_a_next     = s1_a_reg;
    s1_b_next     = s1_b_reg;
    s1_cin_next   = s1_cin_reg;
    if (in_fire) begin
      s1_valid_next = 1'b1;
      s1_a_next     = in_a;
      s1_b_next     = in_b;
      s1_cin_next   = in_cin;
    end else if (s2_load) begin
      s1_valid_next = 1'b0;
    end
  end

  // Stage 2 next state: capture the adder result on a load, drop valid
  // after an output transfer with no replacement, otherwise hold stable.
  always_comb begin
    s2_valid_next = s2_valid_reg;
    out_f_next    = out_f_reg;
    out_cout_next = out_cout_reg;
    out_ovf_next  = out_ovf_reg;
    if (s2_load) begin
      s2_valid_next = 1'b1;
      out_f_next    = add_f;
      out_cout_next = add_cout;
      out_ovf_next  = ovf_calc;
    end else if (out_fire) begin
      s2_valid_next = 1'b0;
    end
  end

  // Saturating count of completed output transfers.
  always_comb begin
    op_count_next = op_count_reg;
    if (out_fire && (op_count_reg != CNT_MAX)) begin
      op_count_next = op_count_reg + CNT_ONE;
    end
  end

  // Stage 1 register bank; reset discards any in-flight operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_cin_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      s1_a_reg     <= s1_a_next;
      s1_b_reg     <= s1_b_next;
      s1_cin_reg   <= s1_cin_next;
    end
  end

  // Stage 2 register bank and counter; reset clears the result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      out_f_reg    <= '0;
      out_cout_reg <= 1'b0;
      out_ovf_reg  <= 1'b0;
      op_count_reg <= '0;
    end else begin
      s2_valid_reg <= s2_valid_next;
      out_f_reg    <= out_f_next;
      out_cout_reg <= out_cout_next;
      out_ovf_reg  <= out_ovf_next;
      op_count_reg <= op_count_next;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_f     = out_f_reg;
  assign out_cout  = out_cout_reg;
  assign out_ovf   = out_ovf_reg;
  assign op_count  = op_count_reg;

`ifdef ADDER_ISSUE_CHECK_EN
  // Reference sum of the stage-1 operands, one bit wider for the carry.
  logic [WIDTH:0] chk_sum;
  logic           chk_err_reg, chk_err_next;

  assign chk_sum = {1'b0, s1_a_reg} + {1'b0, s1_b_reg} + {{WIDTH{1'b0}}, s1_cin_reg};

  // Flag a mismatch between the attached adder and the reference at a load.
  always_comb begin
    chk_err_next = chk_err_reg;
    if (s2_load && (chk_sum != {add_cout, add_f})) begin
      chk_err_next = 1'b1;
    end
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err_reg <= 1'b0;
    end else begin
      chk_err_reg <= chk_err_next;
    end
  end

  assign chk_err = chk_err_reg;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_issue_stage.sv
// tb_adder_issue_stage
//   Directed and randomized bench for adder_issue_stage. A behavioural adder
//   stub (with an optional bit-0 corruption) closes the loop, and a queue of
//   accepted operations predicts every output, handshake and counter value.
//   Honours ADDER_ISSUE_CHECK_EN for the expected chk_err value.
module tb_adder_issue_stage;

  localparam int W = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_f;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_f;
  logic          out_cout;
  logic          out_ovf;
  logic [CW-1:0] op_count;
  logic          chk_err;
  logic          corrupt;

  always #5 clk = ~clk;

  adder_issue_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_f(add_f), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_cout(out_cout), .out_ovf(out_ovf),
    .op_count(op_count), .chk_err(chk_err)
  );

  // Behavioural adder stub; corrupt flips bit 0 of the sum.
  logic [W:0] raw_sum;
  assign raw_sum  = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_f    = raw_sum[W-1:0] ^ {{(W-1){1'b0}}, corrupt};
  assign add_cout = raw_sum[W];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           k;    // edge number at which the operand was accepted
    logic         bad;  // adder was corrupting while this op was in flight
  } op_t;

  op_t           q[$];
  int            e = 0;
  int            n_assert = 0;
  int            n_fail = 0;
  logic [CW-1:0] cnt_exp = '0;
  logic          chk_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {ovf, cout, f} from plain arithmetic on the operands.
  function automatic logic [W+1:0] ref_res(input op_t o);
    logic [W:0]   s;
    logic [W-1:0] f;
    s = {1'b0, o.a} + {1'b0, o.b} + {{W{1'b0}}, o.cin};
    f = s[W-1:0] ^ {{(W-1){1'b0}}, o.bad};
    return {(o.a[W-1] == o.b[W-1]) && (f[W-1] != o.a[W-1]), s[W], f};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = c;
    out_ready = ordy;
    #1;
  endtask

  // One clock: check everything at the falling edge, then update the model.
  task automatic tick();
    logic         exp_vld;
    logic         exp_rdy;
    logic         in_fire;
    logic         out_fire;
    logic [W+1:0] r;
    op_t          s1;
    bit           s1_has;
    @(negedge clk);
    exp_vld = (q.size() > 0) && (e > q[0].k);
    exp_rdy = !((q.size() == 2) && !out_ready);
    chk("out_valid", 64'(out_valid), 64'(exp_vld));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_vld) begin
      r = ref_res(q[0]);
      chk("out_f", 64'(out_f), 64'(r[W-1:0]));
      chk("out_cout", 64'(out_cout), 64'(r[W]));
      chk("out_ovf", 64'(out_ovf), 64'(r[W+1]));
    end
    s1_has = 1'b0;
    s1 = '{default: '0};
    if (q.size() == 2) begin
      s1 = q[1];
      s1_has = 1'b1;
    end else if ((q.size() == 1) && (e == q[0].k)) begin
      s1 = q[0];
      s1_has = 1'b1;
    end
    if (s1_has) begin
      chk("add_a", 64'(add_a), 64'(s1.a));
      chk("add_b", 64'(add_b), 64'(s1.b));
      chk("add_cin", 64'(add_cin), 64'(s1.cin));
    end else begin
      chk("add_idle", 64'({add_a, add_b, add_cin}), 64'(0));
    end
    chk("op_count", 64'(op_count), 64'(cnt_exp));
    chk("chk_err", 64'(chk_err), 64'(chk_exp));
    in_fire  = in_valid && exp_rdy;
    out_fire = exp_vld && out_ready;
    @(posedge clk);
    e++;
    if (out_fire) begin
      void'(q.pop_front());
      cnt_exp = (cnt_exp == CMAX) ? CMAX : CW'(cnt_exp + 1'b1);
    end
    if (in_fire) q.push_back('{in_a, in_b, in_cin, e, corrupt});
`ifdef ADDER_ISSUE_CHECK_EN
    if ((q.size() > 0) && q[0].bad && (e > q[0].k)) chk_exp = 1'b1;
`endif
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    drive(1'b1, a, b, c, 1'b1);
    tick();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    corrupt = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_f", 64'(out_f), 64'(0));
    chk("rst_out_cout", 64'(out_cout), 64'(0));
    chk("rst_out_ovf", 64'(out_ovf), 64'(0));
    chk("rst_op_count", 64'(op_count), 64'(0));
    chk("rst_chk_err", 64'(chk_err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));
    tick();

    // positive overflow
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_f", 64'(out_f), 64'h8000_0000);
    chk("t1_cout", 64'(out_cout), 64'(0));
    chk("t1_ovf", 64'(out_ovf), 64'(1));
    tick();
    chk("t1_count", 64'(op_count), 64'(1));

    // negative overflow followed by carry-in case
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    send(32'd10, 32'd15, 1'b1);
    chk("t2_f", 64'(out_f), 64'h7FFF_FFFF);
    chk("t2_cout", 64'(out_cout), 64'(1));
    chk("t2_ovf", 64'(out_ovf), 64'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("t3_f", 64'(out_f), 64'd26);
    chk("t3_cout", 64'(out_cout), 64'(0));
    chk("t3_ovf", 64'(out_ovf), 64'(0));
    tick();

    // back-to-back stream
    send(32'd100, 32'hFFFF_FFCE, 1'b0);
    send(32'd50, 32'd30, 1'b0);
    chk("s1_f", 64'(out_f), 64'd50);
    chk("s1_cout", 64'(out_cout), 64'(1));
    chk("s1_rdy", 64'(in_ready), 64'(1));
    send(32'hFFFF_FFE2, 32'hFFFF_FFEC, 1'b0);
    chk("s2_f", 64'(out_f), 64'd80);
    chk("s2_cout", 64'(out_cout), 64'(0));
    chk("s2_rdy", 64'(in_ready), 64'(1));
    send(32'd0, 32'd0, 1'b1);
    chk("s3_f", 64'(out_f), 64'hFFFF_FFCE);
    chk("s3_cout", 64'(out_cout), 64'(1));
    chk("s3_rdy", 64'(in_ready), 64'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("s4_f", 64'(out_f), 64'd1);
    chk("s4_cout", 64'(out_cout), 64'(0));
    tick();

    // stall: five cycles of out_ready=0 while offering three ops
    drive(1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd3, 32'd4, 1'b0, 1'b0);
    tick();
    chk("stall_rdy", 64'(in_ready), 64'(0));
    chk("stall_f", 64'(out_f), 64'd3);
    drive(1'b1, 32'd5, 32'd6, 1'b0, 1'b0);
    repeat (3) tick();
    chk("stall_hold_f", 64'(out_f), 64'd3);
    chk("stall_hold_valid", 64'(out_valid), 64'(1));
    drive(1'b1, 32'd5, 32'd6, 1'b0, 1'b1);
    chk("release_rdy", 64'(in_ready), 64'(1));
    tick();
    chk("release_f", 64'(out_f), 64'd7);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("release_f2", 64'(out_f), 64'd11);
    tick();

    // reset with both stages full
    drive(1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd8, 32'd8, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_count", 64'(op_count), 64'(0));
    chk("mid_rst_f", 64'(out_f), 64'(0));
    in_valid = 1'b0;
    q.delete();
    cnt_exp = '0;
    chk_exp = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (3) tick();

    // randomized traffic, long enough to saturate the counter
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("sat_count", 64'(op_count), 64'(CMAX));

    // faulty adder: sum bit 0 inverted
    corrupt = 1'b1;
    send(32'h1234_5678, 32'h0000_0001, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    corrupt = 1'b0;
`ifdef ADDER_ISSUE_CHECK_EN
    chk("chk_err_set", 64'(chk_err), 64'(1));
`else
    chk("chk_err_off", 64'(chk_err), 64'(0));
`endif
    send(32'd2, 32'd3, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (3) tick();
`ifdef ADDER_ISSUE_CHECK_EN
    chk("chk_err_sticky", 64'(chk_err), 64'(1));
`else
    chk("chk_err_still_off", 64'(chk_err), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
